// File: rtl/hyper_read_packer.sv
// Packs 16-bit HyperBus read words from the CDC FIFO into little-endian 32-bit beats
// with byte strobes, a last flag and a watchdog abort when the RAM stops delivering.
module hyper_read_packer #(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk0,
    input  logic             rst_i,
    input  logic             trans_valid_i,
    output logic             trans_ready_o,
    input  logic [LEN_W-1:0] trans_words_i,
    input  logic             trans_odd_i,
    input  logic             fifo_valid_i,
    input  logic [15:0]      fifo_data_i,
    output logic             fifo_ready_o,
    input  logic             rx_ready_i,
    output logic             rx_valid_o,
    output logic [31:0]      rx_data_o,
    output logic [3:0]       rx_strb_o,
    output logic             rx_last_o,
    output logic             rx_error_o,
    output logic             busy_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic             half;
    logic [31:0]      stage_data;
    logic [3:0]       stage_strb;
    logic [WD_W-1:0]  wd;

    logic        out_free;
    logic        word_acc;
    logic        last_word;
    logic        beat_word;
    logic        timeout;
    logic        starve;
    logic [31:0] merged_data;
    logic [3:0]  merged_strb;

    always_comb begin
        out_free      = !rx_valid_o || rx_ready_i;
        trans_ready_o = (state == IDLE);
        busy_o        = (state != IDLE);
        fifo_ready_o  = 1'b0;
        state_next    = state;

        case (state)
            IDLE:    fifo_ready_o = 1'b1;
            COLLECT: fifo_ready_o = out_free;
            default: fifo_ready_o = 1'b0;
        endcase

        word_acc    = (state == COLLECT) && fifo_valid_i && out_free;
        last_word   = word_acc && (remaining == LEN_W'(1));
        beat_word   = word_acc && (half || last_word);
        // Only starvation counts toward the watchdog; a stalled output keeps fifo_ready_o low.
        starve      = (state == COLLECT) && out_free && !fifo_valid_i;
        timeout     = starve && (wd == WD_MAX);
        merged_data = half ? {fifo_data_i, stage_data[15:0]} : {stage_data[31:16], fifo_data_i};
        merged_strb = half ? {2'b11, stage_strb[1:0]} : {stage_strb[3:2], 2'b11};

        case (state)
            IDLE: begin
                if (trans_valid_i && (trans_words_i != '0)) state_next = COLLECT;
            end
            COLLECT: begin
                if (last_word || timeout) state_next = DRAIN;
            end
            DRAIN: begin
                if (rx_valid_o && rx_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk0 or posedge rst_i) begin
        if (rst_i) begin
            remaining  <= '0;
            half       <= 1'b0;
            stage_data <= '0;
            stage_strb <= '0;
            wd         <= '0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_strb_o  <= '0;
            rx_last_o  <= 1'b0;
            rx_error_o <= 1'b0;
        end else begin
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (trans_valid_i && (trans_words_i != '0)) begin
                        remaining  <= trans_words_i;
                        half       <= trans_odd_i;
                        stage_data <= '0;
                        stage_strb <= '0;
                        wd         <= '0;
                    end
                end
                COLLECT: begin
                    if (word_acc) begin
                        remaining <= remaining - LEN_W'(1);
                        wd        <= '0;
                        if (beat_word) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= merged_data;
                            rx_strb_o  <= merged_strb;
                            rx_last_o  <= last_word;
                            rx_error_o <= 1'b0;
                            stage_data <= '0;
                            stage_strb <= '0;
                            half       <= 1'b0;
                        end else begin
                            stage_data <= merged_data;
                            stage_strb <= merged_strb;
                            half       <= ~half;
                        end
                    end else if (timeout) begin
                        rx_valid_o <= 1'b1;
                        rx_data_o  <= stage_data;
                        rx_strb_o  <= stage_strb;
                        rx_last_o  <= 1'b1;
                        rx_error_o <= 1'b1;
                        remaining  <= '0;
                        stage_data <= '0;
                        stage_strb <= '0;
                        half       <= 1'b0;
                        wd         <= '0;
                    end else if (starve) begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_read_packer.sv
// Directed self-checking bench for hyper_read_packer (TIMEOUT_CYCLES=16).
module tb_hyper_read_packer;

    logic        clk0 = 1'b0;
    logic        rst_i;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic [15:0] trans_words_i;
    logic        trans_odd_i;
    logic        fifo_valid_i;
    logic [15:0] fifo_data_i;
    logic        fifo_ready_o;
    logic        rx_ready_i;
    logic        rx_valid_o;
    logic [31:0] rx_data_o;
    logic [3:0]  rx_strb_o;
    logic        rx_last_o;
    logic        rx_error_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_strb[$];
    logic        q_last[$];
    logic        q_err[$];
    int unsigned q_cyc[$];

    hyper_read_packer #(
        .LEN_W(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk0(clk0),
        .rst_i(rst_i),
        .trans_valid_i(trans_valid_i),
        .trans_ready_o(trans_ready_o),
        .trans_words_i(trans_words_i),
        .trans_odd_i(trans_odd_i),
        .fifo_valid_i(fifo_valid_i),
        .fifo_data_i(fifo_data_i),
        .fifo_ready_o(fifo_ready_o),
        .rx_ready_i(rx_ready_i),
        .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o),
        .rx_strb_o(rx_strb_o),
        .rx_last_o(rx_last_o),
        .rx_error_o(rx_error_o),
        .busy_o(busy_o)
    );

    always #5 clk0 = ~clk0;

    // Record every accepted output beat.
    always @(posedge clk0) begin
        cyc <= cyc + 1;
        if (!rst_i && rx_valid_o && rx_ready_i) begin
            q_data.push_back(rx_data_o);
            q_strb.push_back(rx_strb_o);
            q_last.push_back(rx_last_o);
            q_err.push_back(rx_error_o);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk0);
        @(negedge clk0);
    endtask

    task automatic clear_q();
        q_data.delete(); q_strb.delete(); q_last.delete(); q_err.delete(); q_cyc.delete();
    endtask

    task automatic desc(input logic [15:0] words, input logic odd);
        trans_valid_i = 1'b1;
        trans_words_i = words;
        trans_odd_i   = odd;
        tick();
        trans_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        logic [44:0] exp;
        rst_i = 1'b1;
        trans_valid_i = 0; trans_words_i = '0; trans_odd_i = 0;
        fifo_valid_i = 0; fifo_data_i = '0; rx_ready_i = 1;
        tick(); tick();
        got = {rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o, busy_o, trans_ready_o, fifo_ready_o};
        exp = {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", got, exp);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_aligned();
        clear_q();
        rx_ready_i = 1;
        desc(16'd4, 1'b0);
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL aligned_busy got=%b exp=1", busy_o); end
        fifo_valid_i = 1; fifo_data_i = 16'h1111; tick();
        checks++;
        if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL aligned_early_valid got=%b exp=0", rx_valid_o); end
        fifo_data_i = 16'h2222; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o} !== {1'b1, 32'h22221111, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL aligned_beat1 got v=%b d=%h s=%h l=%b exp v=1 d=22221111 s=f l=0",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o);
        end
        fifo_data_i = 16'h3333; tick();
        checks++;
        if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL aligned_gap_valid got=%b exp=0", rx_valid_o); end
        fifo_data_i = 16'h4444; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o} !== {1'b1, 32'h44443333, 4'hF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL aligned_beat2 got v=%b d=%h s=%h l=%b e=%b exp v=1 d=44443333 s=f l=1 e=0",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o);
        end
        fifo_valid_i = 0; tick();
        checks++;
        if ({busy_o, trans_ready_o} !== 2'b01) begin
            failures++; $display("FAIL aligned_idle_after got busy=%b tr=%b exp busy=0 tr=1", busy_o, trans_ready_o);
        end
        checks++;
        if (q_data.size() != 2) begin
            failures++; $display("FAIL aligned_beat_count got=%0d exp=2", q_data.size());
        end else if (q_cyc[1] - q_cyc[0] != 2) begin
            failures++; $display("FAIL aligned_beat_spacing got=%0d exp=2", q_cyc[1] - q_cyc[0]);
        end
    endtask

    task automatic test_odd_start();
        clear_q();
        desc(16'd3, 1'b1);
        fifo_valid_i = 1; fifo_data_i = 16'hAAAA; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o} !== {1'b1, 32'hAAAA0000, 4'hC, 1'b0}) begin
            failures++;
            $display("FAIL odd_beat1 got v=%b d=%h s=%h l=%b exp v=1 d=aaaa0000 s=c l=0",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o);
        end
        fifo_data_i = 16'hBBBB; tick();
        fifo_data_i = 16'hCCCC; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o} !== {1'b1, 32'hCCCCBBBB, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL odd_beat2 got v=%b d=%h s=%h l=%b exp v=1 d=ccccbbbb s=f l=1",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o);
        end
        fifo_valid_i = 0; tick();
        checks++;
        if (q_data.size() != 2 || busy_o !== 1'b0) begin
            failures++; $display("FAIL odd_done got beats=%0d busy=%b exp beats=2 busy=0", q_data.size(), busy_o);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d[4];
        logic [15:0] lo;
        logic [15:0] hi;
        int idx = 0;
        int budget = 0;
        logic rr = 1'b1;
        logic accepted;
        for (int k = 0; k < 4; k++) begin
            lo = 16'h1001 + 16'(2 * k);
            hi = lo + 16'h1;
            exp_d[k] = {hi, lo};
        end
        clear_q();
        desc(16'd8, 1'b0);
        while (q_data.size() < 4 && budget < 200) begin
            rr = ~rr;
            rx_ready_i = rr;
            if (idx < 8) begin fifo_valid_i = 1; fifo_data_i = 16'h1001 + 16'(idx); end
            else fifo_valid_i = 0;
            #1;
            if (rx_valid_o && !rx_ready_i) begin
                checks++;
                if (fifo_ready_o !== 1'b0) begin
                    failures++; $display("FAIL bp_fifo_ready_stall got=%b exp=0", fifo_ready_o);
                end
            end
            if (rx_valid_o) begin
                checks++;
                if (rx_data_o !== exp_d[q_data.size()]) begin
                    failures++; $display("FAIL bp_beat_data got=%h exp=%h", rx_data_o, exp_d[q_data.size()]);
                end
            end
            accepted = fifo_valid_i && fifo_ready_o;
            tick();
            if (accepted) idx++;
            budget++;
        end
        fifo_valid_i = 0; rx_ready_i = 1;
        tick(); tick();
        checks++;
        if (budget >= 200) begin failures++; $display("FAIL bp_timeout got beats=%0d exp=4", q_data.size()); end
        checks++;
        if (idx != 8) begin failures++; $display("FAIL bp_words_consumed got=%0d exp=8", idx); end
        checks++;
        if (q_data.size() != 4) begin
            failures++; $display("FAIL bp_beat_count got=%0d exp=4", q_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if ({q_data[k], q_strb[k], q_last[k]} !== {exp_d[k], 4'hF, (k == 3)}) begin
                    failures++;
                    $display("FAIL bp_beat%0d got d=%h s=%h l=%b exp d=%h s=f l=%0d",
                             k, q_data[k], q_strb[k], q_last[k], exp_d[k], (k == 3));
                end
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_idle got busy=%b exp=0", busy_o); end
    endtask

    task automatic test_timeout();
        int early = 0;
        int n;
        clear_q();
        rx_ready_i = 1;
        desc(16'd4, 1'b0);
        fifo_valid_i = 1; fifo_data_i = 16'h5A5A; tick();
        fifo_valid_i = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (rx_valid_o) early++;
        end
        checks++;
        if (early != 0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", early); end
        tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o} !== {1'b1, 32'h00005A5A, 4'h3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL timeout_beat got v=%b d=%h s=%h l=%b e=%b exp v=1 d=00005a5a s=3 l=1 e=1",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL timeout_idle got busy=%b exp=0", busy_o); end
        n = q_data.size();
        fifo_valid_i = 1; fifo_data_i = 16'h7777;
        #1;
        checks++;
        if (fifo_ready_o !== 1'b1) begin failures++; $display("FAIL timeout_purge_ready got=%b exp=1", fifo_ready_o); end
        tick();
        fifo_valid_i = 0;
        tick(); tick(); tick();
        checks++;
        if (q_data.size() != n || busy_o !== 1'b0 || n != 1) begin
            failures++; $display("FAIL timeout_late_word got beats=%0d busy=%b exp beats=1 busy=0", q_data.size(), busy_o);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        desc(16'd0, 1'b0);
        checks++;
        if ({busy_o, trans_ready_o} !== 2'b01) begin
            failures++; $display("FAIL zero_len_state got busy=%b tr=%b exp busy=0 tr=1", busy_o, trans_ready_o);
        end
        desc(16'd2, 1'b0);
        fifo_valid_i = 1; fifo_data_i = 16'hBEEF; tick();
        fifo_data_i = 16'hCAFE; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o} !== {1'b1, 32'hCAFEBEEF, 4'hF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_beat got v=%b d=%h s=%h l=%b e=%b exp v=1 d=cafebeef s=f l=1 e=0",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o);
        end
        fifo_valid_i = 0; tick();
        checks++;
        if (q_data.size() != 1 || busy_o !== 1'b0) begin
            failures++; $display("FAIL b2b_done got beats=%0d busy=%b exp beats=1 busy=0", q_data.size(), busy_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [44:0] got;
        clear_q();
        desc(16'd4, 1'b0);
        fifo_valid_i = 1; fifo_data_i = 16'h1234; tick();
        fifo_valid_i = 0;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_o); end
        #2 rst_i = 1'b1;
        #1;
        got = {rx_valid_o, rx_data_o, rx_strb_o, rx_last_o, rx_error_o, busy_o, trans_ready_o, fifo_ready_o};
        checks++;
        if (got !== {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++; $display("FAIL rstmid_async got=%h exp=%h", got, {1'b0, 32'h0, 4'h0, 5'b00011});
        end
        @(posedge clk0); @(negedge clk0);
        rst_i = 1'b0;
        tick();
        desc(16'd2, 1'b0);
        fifo_valid_i = 1; fifo_data_i = 16'h0A0B; tick();
        fifo_data_i = 16'h0C0D; tick();
        checks++;
        if ({rx_valid_o, rx_data_o, rx_strb_o, rx_last_o} !== {1'b1, 32'h0C0D0A0B, 4'hF, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_new_beat got v=%b d=%h s=%h l=%b exp v=1 d=0c0d0a0b s=f l=1",
                     rx_valid_o, rx_data_o, rx_strb_o, rx_last_o);
        end
        fifo_valid_i = 0; tick();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_odd_start();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
